// File: rtl/bist_signature_engine.sv
// -----------------------------------------------------------------------------
// bist_signature_engine
//
// Datapath half of the built-in self-test. The BIST control FSM drives
// mode/init/running/finish. This block uses them to:
//   * generate pseudo-random patterns with a Galois LFSR, sent toward the
//     unit under test through the test_data mux;
//   * compact the unit-under-test responses into a Galois MISR signature;
//   * count the applied patterns;
//   * compare the final signature against GOLDEN and report done/pass.
// In functional mode (mode=0) test_data is simply func_data.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-low reset
//   mode           1 = BIST, 0 = functional
//   init           seed request (reload LFSR, clear MISR/count/result)
//   running        apply/capture enable, one pattern per cycle
//   finish         end of test, triggers the signature compare
//   func_data      functional data toward the unit under test
//   dut_response   unit-under-test output, sampled on capture cycles
//   test_data      mode ? lfsr : func_data
//   pattern_count  patterns applied since the last init (saturating)
//   signature      current MISR contents
//   done           compare complete (held until init, mode=0 or reset)
//   pass           signature matched GOLDEN; meaningful only while done=1
// -----------------------------------------------------------------------------
module bist_signature_engine #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_POLY = 8'hB8,
  parameter logic [WIDTH-1:0] MISR_POLY = 8'hB8,
  parameter logic [WIDTH-1:0] SEED      = 8'h01,
  parameter logic [WIDTH-1:0] GOLDEN    = 8'h5C
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             init,
  input  logic             running,
  input  logic             finish,
  input  logic [WIDTH-1:0] func_data,
  input  logic [WIDTH-1:0] dut_response,
  output logic [WIDTH-1:0] test_data,
  output logic [15:0]      pattern_count,
  output logic [WIDTH-1:0] signature,
  output logic             done,
  output logic             pass
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [WIDTH-1:0] SEED_EFF =
    (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    CHECK,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] misr;

  // Right-shift Galois step: shift out bit 0, fold the mask in when it was 1.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] poly);
    return x[0] ? ((x >> 1) ^ poly) : (x >> 1);
  endfunction

  // NOTE: test_data is a pure combinational mux so the unit under test sees
  // the current pattern in the same cycle its response is captured.
  assign test_data = mode ? lfsr : func_data;
  assign signature = misr;

  // Priority: reset > mode=0 > init > finish > running.
  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others (the MISR must see the
  // response to the pattern currently on test_data, not the next one).
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      lfsr          <= SEED_EFF;
      misr          <= '0;
      pattern_count <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else if (!mode) begin
      // Functional mode: abandon any test but keep the datapath contents.
      state <= IDLE;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else if (init) begin
      // Seed cycle only; a simultaneous running is deliberately not captured.
      state         <= ARMED;
      lfsr          <= SEED_EFF;
      misr          <= '0;
      pattern_count <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      unique case (state)
        ARMED, RUN: begin
          if (finish) begin
            state <= CHECK;
          end else if (running) begin
            misr          <= step(misr, MISR_POLY) ^ dut_response;
            lfsr          <= step(lfsr, LFSR_POLY);
            pattern_count <= (pattern_count == 16'hFFFF) ? pattern_count
                                                         : pattern_count + 16'd1;
            state         <= RUN;
          end
          // running=0, finish=0: pause, everything holds.
        end
        CHECK: begin
          pass  <= (misr == GOLDEN);
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          // IDLE and DONE ignore running/finish; only init or mode=0 leave.
        end
      endcase
    end
  end

endmodule

// File: doc/bist_signature_engine.md
Name: bist_signature_engine

Overview:
- Datapath companion to the BIST control state machine; sits directly downstream of it and consumes its mode/init/running/finish outputs.
- Generates LFSR test patterns toward the unit under test and compacts the responses into a MISR signature.
- Counts applied patterns, compares the final signature with a golden value and reports done/pass.
- In functional mode it is a transparent mux on the unit-under-test input path.

Parameters:
- WIDTH, 8: pattern/response/signature width in bits (>=4).
- LFSR_POLY, 8'hB8: Galois feedback mask for the pattern LFSR (right-shift form).
- MISR_POLY, 8'hB8: Galois feedback mask for the MISR.
- SEED, 8'h01: LFSR load value. Zero is illegal; RTL substitutes 1.
- GOLDEN, 8'h5C: expected final signature.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- mode  in  1  1 = BIST, 0 = functional.
- init  in  1  seed request from the control FSM.
- running  in  1  apply/capture enable, one pattern per cycle.
- finish  in  1  end of test; triggers the compare.
- func_data  in  WIDTH  functional data toward the unit under test.
- dut_response  in  WIDTH  unit-under-test output, sampled while running.
- test_data  out  WIDTH  mode ? lfsr : func_data (combinational mux).
- pattern_count  out  16  patterns applied since last init.
- signature  out  WIDTH  current MISR contents.
- done  out  1  compare complete (level, held).
- pass  out  1  signature == GOLDEN. Valid only while done=1.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE, lfsr=SEED, misr=0, pattern_count=0, done=0, pass=0.
  - reset overrides all other inputs.
- step(x, P) = x[0] ? ((x>>1) ^ P) : (x>>1).
- States: IDLE, ARMED, RUN, CHECK, DONE.
- Input priority each cycle: reset > mode=0 > init > finish > running.
- mode=0 in any state:
  - next state IDLE; done=0, pass=0.
  - lfsr, misr and count are left unchanged.
  - test_data=func_data.
- init=1 with mode=1, from any state:
  - lfsr<=SEED, misr<=0, count<=0, done<=0, pass<=0.
  - next state ARMED; a running in the same cycle is ignored.
- Capture cycle (state ARMED or RUN, running=1, finish=0):
  - misr <= step(misr, MISR_POLY) ^ dut_response, where dut_response is the response to the current test_data.
  - lfsr <= step(lfsr, LFSR_POLY).
  - count <= count+1, saturating at 16'hFFFF.
  - state RUN.
- ARMED/RUN with running=0, finish=0: hold all registers (pause).
- finish=1 in ARMED or RUN:
  - no capture that cycle, even if running=1.
  - next state CHECK.
- CHECK (one cycle): pass <= (misr==GOLDEN), done <= 1, next state DONE.
  - done and pass become visible one cycle after CHECK is entered.
- DONE:
  - holds done, pass, signature and count.
  - running and finish are ignored; only init or mode=0 leave DONE.
- IDLE:
  - running and finish are ignored.
  - signature and count keep their last values.
- finish in IDLE: ignored, done stays 0.
- Latency: no capture in the init cycle; the first capture happens on the cycle after init. test_data shows SEED during ARMED.

Test Plan:
- Reset/idle:
  - Stimulus: hold reset=0 for 2 cycles, then mode=1, no init.
  - Required: test_data=8'h01, signature=0, pattern_count=0, done=0, pass=0.
  - Then mode=0, func_data=8'hA5 -> test_data=8'hA5.
- Pattern sequence:
  - Stimulus: init, then running for 5 cycles, with dut_response looped from test_data.
  - Required: test_data=01, B8, 5C, 2E, 17, then B3 after the 5th capture; pattern_count=5.
- Pass:
  - Stimulus: init, running for 3 cycles with loopback, then finish.
  - Required: signature=8'h5C, pattern_count=3; one cycle after CHECK, done=1 and pass=1, held until the next init.
- Fail (stuck bit):
  - Stimulus: same as Pass but dut_response = test_data ^ 8'h01.
  - Required: signature=8'hB9, done=1, pass=0.
- Priority/pause:
  - running=0 for 2 cycles mid-run -> all registers frozen.
  - finish and running together -> no capture, count unchanged.
  - init during RUN -> lfsr=01, count=0, state ARMED.
- Abort:
  - mode=0 during RUN -> IDLE next cycle, done=0, test_data=func_data.
  - reset=0 during DONE -> all outputs return to reset values at that edge.
